// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: FSM state encodings, the
//   legal WIDTH range, and a helper that sizes the shift-edge counter.
//   No ports (package).
// ---------------------------------------------------------------------------
package serial_adder_pkg;

    // FSM encodings. The fourth encoding (2'd3) is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    // Counter must represent 0..WIDTH, so it never wraps inside an operation.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//   1-bit full-adder cell.
//   Ports:
//     a_i, b_i  : operand bits
//     ci_i      : carry in
//     s_o       : sum bit
//     co_o      : carry out
// ---------------------------------------------------------------------------
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    logic p;

    assign p    = a_i ^ b_i;
    assign s_o  = p ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & p);

endmodule : full_adder

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder: computes a + b + cin one bit per clock through a single
//   1-bit full-adder cell. One result every WIDTH+2 cycles.
//   Parameters:
//     WIDTH      : operand/result width, legal range 2..32
//   Ports:
//     clk        : clock, rising edge
//     rst        : synchronous active-high reset (priority over start)
//     start      : request; only sampled while idle
//     a, b, cin  : operands, captured on the accepting edge only
//     busy       : high whenever the FSM is not IDLE
//     done       : one-cycle completion pulse (registered)
//     sum, cout  : registered result, held until the next completion or reset
//     state_dbg  : current FSM state encoding (observation only)
//
//   Handshake: a request is accepted on any rising edge where start=1 and
//   busy=0 (and rst=0). start is ignored while busy=1. Completion is signalled
//   by done=1 for exactly one cycle, with sum/cout already valid in that
//   cycle. There is no backpressure on the result.
// ---------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       state_dbg
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               done_q, done_d;

    logic               fa_s;
    logic               fa_co;
    logic               last_shift;

    full_adder u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .ci_i (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    // Counter holds the number of shift edges already taken; the edge on
    // which it reads WIDTH-1 is the WIDTH-th and final shift.
    assign last_shift = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                // Sum bits enter at the MSB end, so after WIDTH shifts the
                // first (LSB) sum bit has walked down to bit 0.
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_shift) begin
                    sum_d   = res_d;
                    cout_d  = fa_co;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign state_dbg = state_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the main scenarios
// and a 2-bit instance for the exhaustive small-width sweep.
module tb_serial_adder;

  logic       clk;
  logic       rst;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic [1:0] st8;

  logic       start2;
  logic [1:0] a2, b2;
  logic       cin2;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;
  logic [1:0] st2;

  int checks;
  int errors;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .busy      (busy8),
    .done      (done8),
    .sum       (sum8),
    .cout      (cout8),
    .state_dbg (st8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .start     (start2),
    .a         (a2),
    .b         (b2),
    .cin       (cin2),
    .busy      (busy2),
    .done      (done2),
    .sum       (sum2),
    .cout      (cout2),
    .state_dbg (st2)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present one request on the 8-bit DUT, release start after the
  // accepting edge, count edges (accepting edge included) until done is seen.
  task automatic run_op8(input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, output int lat,
                         output logic [7:0] s, output logic co);
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (done8 !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    s  = sum8;
    co = cout8;
  endtask

  task automatic run_op2(input logic [1:0] av, input logic [1:0] bv,
                         input logic cv, output int lat,
                         output logic [1:0] s, output logic co);
    @(negedge clk);
    a2 = av; b2 = bv; cin2 = cv; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 1;
    while (done2 !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    s  = sum2;
    co = cout2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start2 = 1'b0; a2 = 2'h0;  b2 = 2'h0;  cin2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy8); end
    checks++;
    if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done8); end
    checks++;
    if (sum8 !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h expected 00", sum8); end
    checks++;
    if (cout8 !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout8); end
    checks++;
    if (st8 !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", st8); end
    checks++;
    if ({busy2, done2, cout2, sum2} !== 5'b0) begin
      errors++; $display("FAIL reset_w2: got busy=%b done=%b cout=%b sum=%h expected all 0", busy2, done2, cout2, sum2);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    logic [7:0] s;
    logic co;
    run_op8(8'h5A, 8'h33, 1'b0, lat, s, co);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL basic_latency: got %0d expected 9", lat); end
    checks++;
    if (s !== 8'h8D) begin errors++; $display("FAIL basic_sum: got %h expected 8d", s); end
    checks++;
    if (co !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b expected 0", co); end
    checks++;
    if (busy8 !== 1'b1) begin errors++; $display("FAIL basic_busy_in_done: got %b expected 1", busy8); end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", done8); end
    checks++;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL basic_idle_after: got %b expected 0", busy8); end
    checks++;
    if (sum8 !== 8'h8D) begin errors++; $display("FAIL basic_sum_held: got %h expected 8d", sum8); end
  endtask

  task automatic test_carry();
    int lat;
    logic [7:0] s;
    logic co;
    run_op8(8'hFF, 8'h01, 1'b0, lat, s, co);
    checks++;
    if ({co, s} !== 9'h100) begin errors++; $display("FAIL carry_ff_01: got cout=%b sum=%h expected cout=1 sum=00", co, s); end
    @(negedge clk);
    run_op8(8'hFF, 8'hFF, 1'b1, lat, s, co);
    checks++;
    if ({co, s} !== 9'h1FF) begin errors++; $display("FAIL carry_ff_ff_1: got cout=%b sum=%h expected cout=1 sum=ff", co, s); end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL carry_latency: got %0d expected 9", lat); end
    @(negedge clk);
  endtask

  // start held for 20 edges; operands disturbed while the adder is busy.
  task automatic test_back_to_back();
    int n_done;
    int t_first;
    int t_second;
    logic [7:0] s_first;
    logic [7:0] s_second;
    n_done = 0; t_first = -1; t_second = -1; s_first = 8'h00; s_second = 8'h00;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        n_done++;
        if (n_done == 1) begin t_first = i; s_first = sum8; end
        if (n_done == 2) begin t_second = i; s_second = sum8; end
      end
      if (i == 3 || i == 13) begin a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; end
      if (i == 8) begin a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; end
      if (i == 15) begin
        checks++;
        if (sum8 !== 8'h03) begin errors++; $display("FAIL b2b_sum_held_mid_op: got %h expected 03", sum8); end
      end
    end
    start8 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) n_done++;
    end
    checks++;
    if (n_done !== 2) begin errors++; $display("FAIL b2b_pulse_count: got %0d expected 2", n_done); end
    checks++;
    if (t_first !== 9) begin errors++; $display("FAIL b2b_first_time: got %0d expected 9", t_first); end
    checks++;
    if (t_second - t_first !== 10) begin errors++; $display("FAIL b2b_spacing: got %0d expected 10", t_second - t_first); end
    checks++;
    if (s_first !== 8'h03) begin errors++; $display("FAIL b2b_sum_first: got %h expected 03", s_first); end
    checks++;
    if (s_second !== 8'h03) begin errors++; $display("FAIL b2b_sum_second: got %h expected 03", s_second); end
  endtask

  task automatic test_rst_abort();
    int lat;
    int n_done;
    logic [7:0] s;
    logic co;
    run_op8(8'h5A, 8'h33, 1'b0, lat, s, co);
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sum8 !== 8'h8D) begin errors++; $display("FAIL abort_prior_sum: got %h expected 8d", sum8); end
    checks++;
    if (busy8 !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", busy8); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy8); end
    checks++;
    if ({cout8, sum8} !== 9'h000) begin errors++; $display("FAIL abort_result: got cout=%b sum=%h expected cout=0 sum=00", cout8, sum8); end
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) n_done++;
    end
    checks++;
    if (n_done !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", n_done); end
    // start together with rst on one edge, then accepted on the first edge without rst
    rst = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL rst_over_start: got busy=%b expected 0", busy8); end
    rst = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin errors++; $display("FAIL start_after_rst: got busy=%b expected 1", busy8); end
    lat = 1;
    while (done8 !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if ({cout8, sum8} !== 9'h030 || lat !== 9) begin
      errors++; $display("FAIL start_after_rst_result: got cout=%b sum=%h lat=%0d expected cout=0 sum=30 lat=9", cout8, sum8, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_w2_sweep();
    int lat;
    logic [1:0] s;
    logic co;
    logic [2:0] expv;
    for (int ai = 0; ai < 4; ai++) begin
      for (int bi = 0; bi < 4; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          expv = 3'(ai + bi + ci);
          run_op2(2'(ai), 2'(bi), 1'(ci), lat, s, co);
          checks++;
          if ({co, s} !== expv || lat !== 3) begin
            errors++;
            $display("FAIL w2_sweep a=%0d b=%0d cin=%0d: got {cout,sum}=%0d lat=%0d expected %0d lat=3", ai, bi, ci, {co, s}, lat, expv);
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_rst_abort();
    test_w2_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_adder
